// File: rtl/spi_xfer_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : spi_xfer_sequencer_if
//  Description : Bundles the client request/response handshake, the SPI
//                configuration inputs and the APB master bus used by
//                spi_xfer_sequencer.
//                master : sequencer view (drives APB and responses)
//                slave  : environment view (client logic + APB slave)
//  Ports       : req_valid/req_ready/req_wdata     - client byte request
//                cfg_cr1/cfg_cr2/cfg_baud/cfg_update - SPI configuration
//                rsp_valid/rsp_rdata/rsp_err/rsp_timeout, busy - response
//                PSEL/PENABLE/PWRITE/PADDR/PWDATA/PRDATA/PREADY/PSLVERR - APB
//  Revision    : 1.0 - initial release
// ============================================================================
interface spi_xfer_sequencer_if;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_wdata;
    logic [7:0] cfg_cr1;
    logic [7:0] cfg_cr2;
    logic [7:0] cfg_baud;
    logic       cfg_update;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       rsp_timeout;
    logic       busy;
    logic       PSEL;
    logic       PENABLE;
    logic       PWRITE;
    logic [2:0] PADDR;
    logic [7:0] PWDATA;
    logic [7:0] PRDATA;
    logic       PREADY;
    logic       PSLVERR;

    modport master (
        input  req_valid, req_wdata, cfg_cr1, cfg_cr2, cfg_baud, cfg_update,
        input  PRDATA, PREADY, PSLVERR,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, busy,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport slave (
        output req_valid, req_wdata, cfg_cr1, cfg_cr2, cfg_baud, cfg_update,
        output PRDATA, PREADY, PSLVERR,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, busy,
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );
endinterface
`default_nettype wire

// File: rtl/spi_xfer_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : spi_xfer_sequencer
//  Description : APB master that drives an APB-attached SPI controller for a
//                single byte-stream client. Reprograms CR1/CR2/BR when the
//                configuration is stale, writes DR, polls SR for SPIF, reads
//                DR and returns the received byte.
//  Ports       : PCLK    - clock
//                PRESETn - asynchronous active-low reset
//                bus     - spi_xfer_sequencer_if.master (client + APB)
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_xfer_sequencer #(
    parameter int POLL_LIMIT = 1024,
    parameter int WAIT_LIMIT = 16,
    parameter int CNT_W      = 11
) (
    input  logic                        PCLK,
    input  logic                        PRESETn,
    spi_xfer_sequencer_if.master        bus
);

    localparam logic [2:0] c_ADDR_CR1 = 3'd0;
    localparam logic [2:0] c_ADDR_CR2 = 3'd1;
    localparam logic [2:0] c_ADDR_BR  = 3'd2;
    localparam logic [2:0] c_ADDR_SR  = 3'd3;
    localparam logic [2:0] c_ADDR_DR  = 3'd5;

    localparam logic [CNT_W-1:0] c_POLL_LAST = CNT_W'(POLL_LIMIT - 1);
    localparam logic [CNT_W-1:0] c_WAIT_LAST = CNT_W'(WAIT_LIMIT - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CFG_CR1 = 3'd1,
        S_CFG_CR2 = 3'd2,
        S_CFG_BR  = 3'd3,
        S_WR_DR   = 3'd4,
        S_POLL_SR = 3'd5,
        S_RD_DR   = 3'd6,
        S_RESP    = 3'd7
    } state_t;

    // Every bus state runs GAP -> SETUP -> ACCESS; GAP supplies the idle
    // cycle between accesses and is skipped on entry from IDLE.
    typedef enum logic [1:0] {
        PH_SETUP  = 2'd0,
        PH_ACCESS = 2'd1,
        PH_GAP    = 2'd2
    } phase_t;

    state_t           r_state,    w_state_nxt;
    phase_t           r_phase,    w_phase_nxt;
    logic [CNT_W-1:0] r_wait_cnt, w_wait_nxt;
    logic [CNT_W-1:0] r_poll_cnt, w_poll_nxt;
    logic             r_cfg_stale;
    logic             r_live;
    logic [7:0]       r_wdata, r_cr1, r_cr2, r_baud;
    logic [7:0]       r_rsp_rdata;
    logic             r_rsp_err, r_rsp_timeout;

    logic             w_req_ready, w_accept, w_bus_state, w_in_cfg;
    logic             w_rsp_load, w_rsp_err, w_rsp_to;
    logic [7:0]       w_rsp_rdata;
    logic             w_stale_set, w_stale_clr;

    // r_live keeps req_ready low while reset is asserted.
    assign w_req_ready = r_live && (r_state == S_IDLE);
    assign w_accept    = bus.req_valid && w_req_ready;
    assign w_bus_state = (r_state != S_IDLE) && (r_state != S_RESP);
    assign w_in_cfg    = (r_state == S_CFG_CR1) || (r_state == S_CFG_CR2) ||
                         (r_state == S_CFG_BR);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state    <= S_IDLE;
            r_phase    <= PH_SETUP;
            r_wait_cnt <= '0;
            r_poll_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_phase    <= w_phase_nxt;
            r_wait_cnt <= w_wait_nxt;
            r_poll_cnt <= w_poll_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_wait_nxt  = r_wait_cnt;
        w_poll_nxt  = r_poll_cnt;
        w_rsp_load  = 1'b0;
        w_rsp_rdata = 8'h00;
        w_rsp_err   = 1'b0;
        w_rsp_to    = 1'b0;
        w_stale_set = 1'b0;
        w_stale_clr = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    // A same-cycle cfg_update forces reprogramming with the
                    // values being shadowed now.
                    w_state_nxt = (r_cfg_stale || bus.cfg_update) ? S_CFG_CR1 : S_WR_DR;
                    w_phase_nxt = PH_SETUP;
                    w_wait_nxt  = '0;
                    w_poll_nxt  = '0;
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
                w_phase_nxt = PH_SETUP;
            end
            default: begin
                case (r_phase)
                    PH_GAP: w_phase_nxt = PH_SETUP;
                    PH_SETUP: begin
                        w_phase_nxt = PH_ACCESS;
                        w_wait_nxt  = '0;
                    end
                    default: begin
                        if (bus.PREADY) begin
                            w_phase_nxt = PH_GAP;
                            if (bus.PSLVERR) begin
                                w_state_nxt = S_RESP;
                                w_rsp_load  = 1'b1;
                                w_rsp_err   = 1'b1;
                                w_stale_set = w_in_cfg;
                            end else begin
                                case (r_state)
                                    S_CFG_CR1: w_state_nxt = S_CFG_CR2;
                                    S_CFG_CR2: w_state_nxt = S_CFG_BR;
                                    S_CFG_BR: begin
                                        w_state_nxt = S_WR_DR;
                                        w_stale_clr = 1'b1;
                                    end
                                    S_WR_DR:   w_state_nxt = S_POLL_SR;
                                    S_POLL_SR: begin
                                        w_poll_nxt = r_poll_cnt + CNT_W'(1);
                                        if (bus.PRDATA[7]) begin
                                            w_state_nxt = S_RD_DR;
                                        end else if (r_poll_cnt == c_POLL_LAST) begin
                                            w_state_nxt = S_RESP;
                                            w_rsp_load  = 1'b1;
                                            w_rsp_to    = 1'b1;
                                        end
                                    end
                                    S_RD_DR: begin
                                        w_state_nxt = S_RESP;
                                        w_rsp_load  = 1'b1;
                                        w_rsp_rdata = bus.PRDATA;
                                    end
                                    default: w_state_nxt = S_IDLE;
                                endcase
                            end
                        end else if (r_wait_cnt == c_WAIT_LAST) begin
                            // Slave hung: the SPI block state is unknown, so
                            // force a full reconfiguration next time.
                            w_state_nxt = S_RESP;
                            w_phase_nxt = PH_GAP;
                            w_rsp_load  = 1'b1;
                            w_rsp_to    = 1'b1;
                            w_stale_set = 1'b1;
                        end else begin
                            w_wait_nxt = r_wait_cnt + CNT_W'(1);
                        end
                    end
                endcase
            end
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_live        <= 1'b0;
            r_cfg_stale   <= 1'b1;
            r_wdata       <= 8'h00;
            r_cr1         <= 8'h00;
            r_cr2         <= 8'h00;
            r_baud        <= 8'h00;
            r_rsp_rdata   <= 8'h00;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            r_live <= 1'b1;
            // cfg_update wins over a completing BR write.
            if (bus.cfg_update || w_stale_set) begin
                r_cfg_stale <= 1'b1;
            end else if (w_stale_clr) begin
                r_cfg_stale <= 1'b0;
            end
            if (w_accept) begin
                r_wdata <= bus.req_wdata;
                r_cr1   <= bus.cfg_cr1;
                r_cr2   <= bus.cfg_cr2;
                r_baud  <= bus.cfg_baud;
            end
            if (w_rsp_load) begin
                r_rsp_rdata   <= w_rsp_rdata;
                r_rsp_err     <= w_rsp_err;
                r_rsp_timeout <= w_rsp_to;
            end
        end
    end

    always_comb begin
        bus.PADDR  = 3'd0;
        bus.PWRITE = 1'b0;
        bus.PWDATA = 8'h00;
        case (r_state)
            S_CFG_CR1: begin bus.PADDR = c_ADDR_CR1; bus.PWRITE = 1'b1; bus.PWDATA = r_cr1;   end
            S_CFG_CR2: begin bus.PADDR = c_ADDR_CR2; bus.PWRITE = 1'b1; bus.PWDATA = r_cr2;   end
            S_CFG_BR:  begin bus.PADDR = c_ADDR_BR;  bus.PWRITE = 1'b1; bus.PWDATA = r_baud;  end
            S_WR_DR:   begin bus.PADDR = c_ADDR_DR;  bus.PWRITE = 1'b1; bus.PWDATA = r_wdata; end
            S_POLL_SR: bus.PADDR = c_ADDR_SR;
            S_RD_DR:   bus.PADDR = c_ADDR_DR;
            default:   bus.PADDR = 3'd0;
        endcase
    end

    assign bus.PSEL        = w_bus_state && (r_phase != PH_GAP);
    assign bus.PENABLE     = w_bus_state && (r_phase == PH_ACCESS);
    assign bus.req_ready   = w_req_ready;
    assign bus.rsp_valid   = (r_state == S_RESP);
    assign bus.rsp_rdata   = r_rsp_rdata;
    assign bus.rsp_err     = r_rsp_err;
    assign bus.rsp_timeout = r_rsp_timeout;
    assign bus.busy        = (r_state != S_IDLE);

endmodule
`default_nettype wire
